huff_table_tx: RTL and testbench
================================

Name: huff_table_tx

Overview:
- Serialises the Huffman code table from the table register file into a UART byte stream. The stream's 3-byte-per-entry record format is what the receive-side lookup-table builder consumes.
- Sits between the table register file (read port) and the UART transmitter (valid/ready byte interface).
- Started by a one-cycle pulse. Walks all symbols, emits a record for every symbol with a non-zero code length, then emits an end-of-table record.

Parameters:
- NUM_SYMBOLS, 256, number of table entries walked (addresses 0..NUM_SYMBOLS-1).
- ADDR_W, 8, width of tbl_addr; must satisfy 2^ADDR_W >= NUM_SYMBOLS.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins a table transfer; ignored while busy=1.
- tbl_addr  out  ADDR_W  table read address; registered.
- tbl_length  in  4  code length of the entry at tbl_addr; valid 1 cycle after tbl_addr changes.
- tbl_path  in  12  code path (LSB-first) of the entry at tbl_addr; same timing as tbl_length.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte when tx_valid&tx_ready at a rising edge.
- busy  out  1  high from the cycle after accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse after the last byte is accepted.
- len_err  out  1  sticky; set when an entry with tbl_length>12 is met; cleared on accepted start.
- entry_count  out  ADDR_W+1  number of records sent in the current/last transfer (terminator excluded).

Behaviour:
- Reset (n_rst=0 at clk edge):
  - state=IDLE.
  - tbl_addr, tx_data, tx_valid, busy, done, len_err and entry_count all 0.
  - Reset mid-transfer aborts immediately; the partial stream is not completed.
- Record format:
  - B0 = symbol (tbl_addr[7:0]).
  - B1 = {path[3:0], length[3:0]}.
  - B2 = path[11:4].
- Terminator: 0x00, 0x00, 0x00. Length field 0 marks end of table.
- States:
  - IDLE: on start → tbl_addr=0, entry_count=0, len_err=0, busy=1 → FETCH.
  - FETCH: wait one cycle for read data → EVAL.
  - EVAL: sample tbl_length/tbl_path into holding registers.
    - length==0 → skip.
    - length>12 → len_err=1, skip.
    - Otherwise → SEND0.
    - Skip: if tbl_addr==NUM_SYMBOLS-1 → END0; else tbl_addr+1 → FETCH.
  - SEND0/SEND1/SEND2: drive tx_data=B0/B1/B2 with tx_valid=1.
    - Advance only on tx_valid&tx_ready. tx_data must stay stable while tx_valid=1 and tx_ready=0.
    - On SEND2 accept: entry_count+1. If last address → END0; else tbl_addr+1 → FETCH.
  - END0/END1/END2: send the terminator bytes under the same handshake.
    - END2 accept → DONE (or CSUM if the optional feature is enabled).
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Timing:
  - tx_valid deasserts in FETCH/EVAL. There is a minimum 2-cycle gap between records, and no gap within a record when tx_ready is held high.
  - Best-case latency: start to first tx_valid = 3 cycles.
- Table contents are sampled only in EVAL; changes to the table during a transfer affect only entries not yet read.
- Symbol NUM_SYMBOLS-1 is included; there is no address wrap-around.
- A table with all lengths 0 emits only the terminator, with entry_count=0.
- start during busy, including in the DONE cycle, is ignored.
- tx_ready high while tx_valid=0 has no effect.

Optional Feature:
- Macro HUFF_TX_CHECKSUM_EN.
- Defined:
  - After END2 accept, enter CSUM and send one extra byte = XOR of every byte sent in this transfer, terminator included. Then → DONE.
  - The XOR accumulator clears on accepted start.
- Undefined: no CSUM state and no accumulator; END2 accept → DONE directly.

Test Plan:
- Table with only symbol 0x41 set (length=3, path=0x005), tx_ready=1 → bytes 0x41, 0x53, 0x00, 0x00, 0x00, 0x00; entry_count=1; done pulse; busy low after.
- Symbol 0x7A with length=12, path=0xABC; tx_ready toggling 1-of-3 cycles → bytes 0x7A, 0xCC, 0xAB held stable until each is accepted.
- Symbol 0xFF with length=1, path=0x001 plus symbol 0x00 with length=2, path=0x002 → records ordered 0x00 then 0xFF, last address included; entry_count=2.
- Symbol 0x10 with length=13 → no record for 0x10; len_err=1 at done; a new start clears len_err.
- n_rst=0 during SEND1, then release → tx_valid=0, busy=0, entry_count=0; a new start restarts from address 0.
- With HUFF_TX_CHECKSUM_EN and the first test's table → extra byte 0x41^0x53 = 0x12 after the terminator, before done.

Source files
------------

// File: rtl/huff_table_tx.sv
`default_nettype none
// ============================================================================
// Module     : huff_table_tx
// Description: Walks the Huffman code table and streams 3-byte records
//              (symbol, {path[3:0],len}, path[11:4]) plus a zero terminator.
//              Define HUFF_TX_CHECKSUM_EN to append an XOR checksum byte.
// Revision   : 1.0 - initial release
// ============================================================================
module huff_table_tx #(
  parameter int NUM_SYMBOLS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [3:0]        tbl_length,
  input  logic [11:0]       tbl_path,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic [ADDR_W:0]   entry_count
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NUM_SYMBOLS - 1);
  localparam logic [3:0]        c_max_len   = 4'd12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_EVAL,
    S_SEND0,
    S_SEND1,
    S_SEND2,
    S_END0,
    S_END1,
    S_END2,
`ifdef HUFF_TX_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              len_err_q;
  logic [ADDR_W:0]   count_q;
  logic [3:0]        len_q;
  logic [11:0]       path_q;
`ifdef HUFF_TX_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic       w_accept;
  logic       w_last;
  logic [7:0] w_sym;

  assign w_accept = tx_valid_q & tx_ready;
  assign w_last   = (addr_q == c_last_addr);
  assign w_sym    = 8'(addr_q);

  assign tbl_addr    = addr_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign len_err     = len_err_q;
  assign entry_count = count_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
      count_q    <= '0;
      len_q      <= '0;
      path_q     <= '0;
`ifdef HUFF_TX_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef HUFF_TX_CHECKSUM_EN
      if (w_accept) csum_q <= csum_q ^ tx_data_q;
`endif
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q    <= '0;
            count_q   <= '0;
            len_err_q <= 1'b0;
            busy_q    <= 1'b1;
`ifdef HUFF_TX_CHECKSUM_EN
            csum_q    <= '0;
`endif
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_EVAL;
        S_EVAL: begin
          len_q  <= tbl_length;
          path_q <= tbl_path;
          if (tbl_length == 4'd0 || tbl_length > c_max_len) begin
            if (tbl_length > c_max_len) len_err_q <= 1'b1;
            // Skipped entry: the terminator follows directly after the last address
            if (w_last) begin
              tx_data_q  <= 8'h00;
              tx_valid_q <= 1'b1;
              state_q    <= S_END0;
            end else begin
              addr_q  <= addr_q + ADDR_W'(1);
              state_q <= S_FETCH;
            end
          end else begin
            tx_data_q  <= w_sym;
            tx_valid_q <= 1'b1;
            state_q    <= S_SEND0;
          end
        end
        S_SEND0: begin
          if (w_accept) begin
            tx_data_q <= {path_q[3:0], len_q};
            state_q   <= S_SEND1;
          end
        end
        S_SEND1: begin
          if (w_accept) begin
            tx_data_q <= path_q[11:4];
            state_q   <= S_SEND2;
          end
        end
        S_SEND2: begin
          if (w_accept) begin
            count_q <= count_q + (ADDR_W+1)'(1);
            if (w_last) begin
              tx_data_q <= 8'h00;
              state_q   <= S_END0;
            end else begin
              tx_valid_q <= 1'b0;
              addr_q     <= addr_q + ADDR_W'(1);
              state_q    <= S_FETCH;
            end
          end
        end
        S_END0: begin
          if (w_accept) begin
            tx_data_q <= 8'h00;
            state_q   <= S_END1;
          end
        end
        S_END1: begin
          if (w_accept) begin
            tx_data_q <= 8'h00;
            state_q   <= S_END2;
          end
        end
        S_END2: begin
          if (w_accept) begin
`ifdef HUFF_TX_CHECKSUM_EN
            // Fold in the byte being accepted now; csum_q has not seen it yet
            tx_data_q <= csum_q ^ tx_data_q;
            state_q   <= S_CSUM;
`else
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
`endif
          end
        end
`ifdef HUFF_TX_CHECKSUM_EN
        S_CSUM: begin
          if (w_accept) begin
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_huff_table_tx.sv
`default_nettype none
// ============================================================================
// Module     : tb_huff_table_tx
// Description: Self-checking bench for huff_table_tx against a table-walk model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_huff_table_tx;

  localparam int NUM_SYMBOLS = 256;
  localparam int ADDR_W      = 8;
  localparam int LIMIT       = 8000;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] tbl_addr;
  logic [3:0]        tbl_length;
  logic [11:0]       tbl_path;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              busy;
  logic              done;
  logic              len_err;
  logic [ADDR_W:0]   entry_count;

  huff_table_tx #(.NUM_SYMBOLS(NUM_SYMBOLS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .tbl_addr(tbl_addr), .tbl_length(tbl_length), .tbl_path(tbl_path),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .len_err(len_err), .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  logic [3:0]  len_mem [NUM_SYMBOLS];
  logic [11:0] path_mem[NUM_SYMBOLS];

  // Synchronous-read table: data follows the address by one cycle
  always @(posedge clk) begin
    tbl_length <= len_mem[tbl_addr];
    tbl_path   <= path_mem[tbl_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rmode = 0;
  int first_valid = -1;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int  exp_cnt;
  bit  exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (n_rst && tx_valid && tx_ready) got.push_back(tx_data);
  end

  // Ready generation plus a hold check on stalled bytes
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev  = 8'h00;
  always @(negedge clk) begin
    if (stall_prev && n_rst) begin
      chk("hold_valid", tx_valid, 1);
      chk("hold_data", tx_data, data_prev);
    end
    if (tx_valid && first_valid < 0) first_valid = cyc;
    case (rmode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = (cyc % 3 == 0);
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    stall_prev = tx_valid && !tx_ready && n_rst;
    data_prev  = tx_data;
  end

  // Reference: walk the table by address and serialise records directly
  function automatic void build_expected();
    logic [7:0] x;
    exp_q.delete();
    exp_cnt = 0;
    exp_err = 1'b0;
    for (int a = 0; a < NUM_SYMBOLS; a++) begin
      if (len_mem[a] > 4'd12) exp_err = 1'b1;
      else if (len_mem[a] != 4'd0) begin
        exp_q.push_back(8'(a));
        exp_q.push_back({path_mem[a][3:0], len_mem[a]});
        exp_q.push_back(path_mem[a][11:4]);
        exp_cnt++;
      end
    end
    repeat (3) exp_q.push_back(8'h00);
    x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
`ifdef HUFF_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  task automatic clear_table();
    for (int a = 0; a < NUM_SYMBOLS; a++) begin
      len_mem[a]  = 4'd0;
      path_mem[a] = 12'd0;
    end
  endtask

  task automatic run_transfer(input string tag, input int mode, input bit poke_done,
                              input int exp_latency);
    int n;
    int start_cyc;
    build_expected();
    got.delete();
    rmode = mode;
    @(negedge clk);
    first_valid = -1;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_len_err_cleared"}, len_err, 0);
    n = 0;
    while (!done && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    if (poke_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_idle_after_done"}, busy, 0);
    chk({tag, "_stream_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({tag, "_byte"}, got[i], exp_q[i]);
    chk({tag, "_entry_count"}, entry_count, exp_cnt);
    chk({tag, "_len_err"}, len_err, exp_err);
    if (exp_latency > 0) chk({tag, "_latency"}, first_valid - start_cyc, exp_latency);
  endtask

  initial begin
    int n;
    clear_table();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tbl_addr", tbl_addr, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_entry_count", entry_count, 0);
    n_rst = 1'b1;
    @(negedge clk);

    // Single symbol 0x41, free-running ready
    len_mem[8'h41] = 4'd3; path_mem[8'h41] = 12'h005;
    run_transfer("single", 0, 1'b0, 0);
    chk("single_b1_const", (got.size() > 1) ? got[1] : 8'hxx, 8'h53);

    // Max length with a 1-of-3 ready; start poked during done is ignored
    clear_table();
    len_mem[8'h7A] = 4'd12; path_mem[8'h7A] = 12'hABC;
    run_transfer("maxlen", 1, 1'b1, 0);

    // First and last addresses; best-case latency from start
    clear_table();
    len_mem[8'hFF] = 4'd1; path_mem[8'hFF] = 12'h001;
    len_mem[8'h00] = 4'd2; path_mem[8'h00] = 12'h002;
    run_transfer("ends", 0, 1'b0, 3);

    // Illegal length is skipped and flagged, then cleared by the next start
    clear_table();
    len_mem[8'h10] = 4'd13; path_mem[8'h10] = 12'h3C5;
    len_mem[8'h20] = 4'd4;  path_mem[8'h20] = 12'h00F;
    run_transfer("lenerr", 2, 1'b0, 0);
    len_mem[8'h10] = 4'd0;
    run_transfer("lenerr_clear", 0, 1'b0, 0);

    // Empty table emits only the terminator
    clear_table();
    run_transfer("empty", 2, 1'b0, 0);

    // Reset while the second byte of a record is on the wire
    clear_table();
    len_mem[8'h05] = 4'd7; path_mem[8'h05] = 12'h5A5;
    got.delete();
    rmode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (got.size() < 1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_send1", got.size(), 1);
    n_rst = 1'b0;
    @(negedge clk);
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_entry_count", entry_count, 0);
    chk("abort_tbl_addr", tbl_addr, 0);
    n_rst = 1'b1;
    run_transfer("restart", 0, 1'b0, 0);

    // Random tables with a mix of ready behaviours
    for (int t = 0; t < 6; t++) begin
      clear_table();
      for (int a = 0; a < NUM_SYMBOLS; a++) begin
        if ($urandom_range(0, 7) == 0) begin
          len_mem[a]  = 4'($urandom_range(1, 15));
          path_mem[a] = 12'($urandom);
        end
      end
      run_transfer("random", int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
